redmule_cfg_regfile: RTL



---
 rtl/redmule_cfg_regfile.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/redmule_cfg_regfile.sv
`default_nettype none
// ============================================================================
// redmule_cfg_regfile : RedMulE periph config regfile, shadow/live banks + job FSM
// Optional macro REDMULE_CFG_READBACK_EN: CFG readback and live alias at 0x80.
// Revision: 1.0
// ============================================================================
module redmule_cfg_regfile #(
  parameter int unsigned SysDataWidth = 32,
  parameter int unsigned NumCfgRegs   = 6,
  parameter int unsigned IdWidth      = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               clear_i,
  input  logic                               periph_req_i,
  output logic                               periph_gnt_o,
  input  logic [SysDataWidth-1:0]            periph_add_i,
  input  logic                               periph_wen_i,
  input  logic [SysDataWidth/8-1:0]          periph_be_i,
  input  logic [SysDataWidth-1:0]            periph_data_i,
  input  logic [IdWidth-1:0]                 periph_id_i,
  output logic [SysDataWidth-1:0]            periph_r_data_o,
  output logic                               periph_r_valid_o,
  output logic [IdWidth-1:0]                 periph_r_id_o,
  output logic [NumCfgRegs*SysDataWidth-1:0] cfg_o,
  output logic                               start_o,
  input  logic                               done_i,
  output logic                               evt_o
);

  localparam int unsigned BeWidth     = SysDataWidth / 8;
  localparam logic [7:0]  AddrTrigger = 8'h00;
  localparam logic [7:0]  AddrJobCnt  = 8'h04;
  localparam logic [7:0]  AddrStatus  = 8'h08;
  localparam logic [7:0]  AddrSoftClr = 8'h0C;
  localparam logic [7:0]  CfgBase     = 8'h40;
`ifdef REDMULE_CFG_READBACK_EN
  localparam logic [7:0]  LiveBase    = 8'h80;
`endif

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RUNNING = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [SysDataWidth-1:0] shadow_q [NumCfgRegs];
  logic [SysDataWidth-1:0] shadow_d [NumCfgRegs];
  logic [SysDataWidth-1:0] live_q   [NumCfgRegs];
  logic [SysDataWidth-1:0] live_d   [NumCfgRegs];
  logic                    dirty_q, dirty_d;
  logic [SysDataWidth-1:0] job_cnt_q, job_cnt_d;
  logic                    start_q, start_d;
  logic                    evt_q, evt_d;
  logic                    r_valid_q, r_valid_d;
  logic [IdWidth-1:0]      r_id_q, r_id_d;
  logic [SysDataWidth-1:0] r_data_q, r_data_d;

  logic [7:0]              addr;
  logic                    unused_addr;
  logic                    trig_hit;
  logic                    stall;
  logic                    wr_gnt;
  logic                    rd_gnt;
  logic                    trig_fire;
  logic                    soft_clr;
  logic                    job_done;
  logic [NumCfgRegs-1:0]   cfg_hit;
  logic [SysDataWidth-1:0] status;
  logic [SysDataWidth-1:0] rdata;

  assign addr        = periph_add_i[7:0];
  assign unused_addr = ^periph_add_i[SysDataWidth-1:8];

  // A trigger in RUNNING must wait until the FSM is back in IDLE; no grants in reset.
  assign trig_hit     = (addr == AddrTrigger);
  assign stall        = periph_req_i & ~periph_wen_i & trig_hit & (state_q == RUNNING);
  assign periph_gnt_o = periph_req_i & rst_ni & ~stall;

  assign wr_gnt    = periph_gnt_o & ~periph_wen_i;
  assign rd_gnt    = periph_gnt_o & periph_wen_i;
  assign trig_fire = wr_gnt & trig_hit & (state_q == IDLE);
  assign soft_clr  = wr_gnt & (addr == AddrSoftClr);
  assign job_done  = (state_q == RUNNING) & done_i;

  always_comb begin
    cfg_hit = '0;
    for (int i = 0; i < NumCfgRegs; i++) begin
      cfg_hit[i] = (addr == (CfgBase + 8'(4 * i)));
    end
  end

  assign status = {{(SysDataWidth-2){1'b0}}, dirty_q, (state_q == RUNNING)};

  always_comb begin
    rdata = '0;
    case (addr)
      AddrJobCnt: rdata = job_cnt_q;
      AddrStatus: rdata = status;
      default:    ;
    endcase
`ifdef REDMULE_CFG_READBACK_EN
    for (int i = 0; i < NumCfgRegs; i++) begin
      if (cfg_hit[i]) rdata = shadow_q[i];
      if (addr == (LiveBase + 8'(4 * i))) rdata = live_q[i];
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trig_fire) state_d = RUNNING;
      RUNNING: if (done_i)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (soft_clr) state_d = IDLE;
  end

  always_comb begin
    shadow_d  = shadow_q;
    live_d    = live_q;
    dirty_d   = dirty_q;
    job_cnt_d = job_cnt_q;
    start_d   = trig_fire;
    evt_d     = job_done;
    for (int i = 0; i < NumCfgRegs; i++) begin
      if (wr_gnt && cfg_hit[i]) begin
        for (int b = 0; b < BeWidth; b++) begin
          if (periph_be_i[b]) shadow_d[i][8*b +: 8] = periph_data_i[8*b +: 8];
        end
        dirty_d = 1'b1;
      end
    end
    if (trig_fire) begin
      live_d  = shadow_q;
      dirty_d = 1'b0;
    end
    if (job_done) job_cnt_d = job_cnt_q + SysDataWidth'(1);
    // Soft clear wipes everything except the response path, so the clear itself is answered.
    if (soft_clr) begin
      for (int i = 0; i < NumCfgRegs; i++) begin
        shadow_d[i] = '0;
        live_d[i]   = '0;
      end
      dirty_d   = 1'b0;
      job_cnt_d = '0;
      start_d   = 1'b0;
      evt_d     = 1'b0;
    end
  end

  assign r_valid_d = periph_gnt_o;
  assign r_id_d    = periph_gnt_o ? periph_id_i : r_id_q;
  assign r_data_d  = rd_gnt ? rdata : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else if (clear_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumCfgRegs; i++) begin
        shadow_q[i] <= '0;
        live_q[i]   <= '0;
      end
      dirty_q   <= 1'b0;
      job_cnt_q <= '0;
      start_q   <= 1'b0;
      evt_q     <= 1'b0;
      r_valid_q <= 1'b0;
      r_id_q    <= '0;
      r_data_q  <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < NumCfgRegs; i++) begin
        shadow_q[i] <= '0;
        live_q[i]   <= '0;
      end
      dirty_q   <= 1'b0;
      job_cnt_q <= '0;
      start_q   <= 1'b0;
      evt_q     <= 1'b0;
      r_valid_q <= 1'b0;
      r_id_q    <= '0;
      r_data_q  <= '0;
    end else begin
      shadow_q  <= shadow_d;
      live_q    <= live_d;
      dirty_q   <= dirty_d;
      job_cnt_q <= job_cnt_d;
      start_q   <= start_d;
      evt_q     <= evt_d;
      r_valid_q <= r_valid_d;
      r_id_q    <= r_id_d;
      r_data_q  <= r_data_d;
    end
  end

  generate
    for (genvar i = 0; i < NumCfgRegs; i++) begin : g_cfg_out
      assign cfg_o[i*SysDataWidth +: SysDataWidth] = live_q[i];
    end
  endgenerate

  assign start_o          = start_q;
  assign evt_o            = evt_q;
  assign periph_r_valid_o = r_valid_q;
  assign periph_r_id_o    = r_id_q;
  assign periph_r_data_o  = r_data_q;

endmodule
`default_nettype wire
